// File: rtl/wt_dcache_rd_arb_if.sv
// Read-port bundle between the dcache requesters, the read arbiter
// and the tag/data arrays.
interface wt_dcache_rd_arb_if #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned TagWidth = 44,
  parameter int unsigned IdxWidth = 8,
  parameter int unsigned OffWidth = 4
);
  logic [NumPorts-1:0]               rd_req_i;
  logic [NumPorts-1:0]               rd_prio_i;
  logic [NumPorts-1:0]               rd_tag_only_i;
  logic [NumPorts-1:0][TagWidth-1:0] rd_tag_i;
  logic [NumPorts-1:0][IdxWidth-1:0] rd_idx_i;
  logic [NumPorts-1:0][OffWidth-1:0] rd_off_i;
  logic [NumPorts-1:0]               rd_ack_o;
  logic [NumPorts-1:0]               rd_rsp_vld_o;
  logic [NumPorts-1:0]               starved_o;

  logic                mem_req_o;
  logic                mem_gnt_i;
  logic [TagWidth-1:0] mem_tag_o;
  logic [IdxWidth-1:0] mem_idx_o;
  logic [OffWidth-1:0] mem_off_o;
  logic                mem_tag_only_o;

  modport slave (
    input  rd_req_i, rd_prio_i, rd_tag_only_i,
    input  rd_tag_i, rd_idx_i, rd_off_i,
    input  mem_gnt_i,
    output rd_ack_o, rd_rsp_vld_o, starved_o,
    output mem_req_o, mem_tag_o, mem_idx_o,
    output mem_off_o, mem_tag_only_o
  );

  modport master (
    output rd_req_i, rd_prio_i, rd_tag_only_i,
    output rd_tag_i, rd_idx_i, rd_off_i,
    output mem_gnt_i,
    input  rd_ack_o, rd_rsp_vld_o, starved_o,
    input  mem_req_o, mem_tag_o, mem_idx_o,
    input  mem_off_o, mem_tag_only_o
  );
endinterface

// File: rtl/wt_dcache_rd_arb.sv
// Dcache read-port arbiter: promoted > high > low, round-robin per class.
// Aging/promotion only exists with WT_DCACHE_RD_ARB_AGING_EN defined.
module wt_dcache_rd_arb #(
  parameter int unsigned NumPorts    = 3,
  parameter int unsigned TagWidth    = 44,
  parameter int unsigned IdxWidth    = 8,
  parameter int unsigned OffWidth    = 4,
  parameter int unsigned StarveLimit = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  wt_dcache_rd_arb_if.slave bus
);

  localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef logic [PW-1:0]       ptr_t;
  typedef logic [NumPorts-1:0] vec_t;
  typedef enum logic [1:0] {
    CL_PRO,
    CL_HI,
    CL_LO
  } cls_e;

  if (NumPorts < 2) begin : g_bad_ports
    $error("NumPorts must be at least 2");
  end
  if (StarveLimit < 1 || StarveLimit > 255) begin : g_bad_limit
    $error("StarveLimit must be in 1..255");
  end

  // First requester at or above ptr, wrapping around.
  function automatic vec_t rr_pick(vec_t req, ptr_t ptr);
    vec_t oh;
    logic found;
    ptr_t j;
    oh = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      j = ptr_t'((32'(ptr) + i) % NumPorts);
      if (!found && req[j]) begin
        oh[j] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic ptr_t enc(vec_t oh);
    ptr_t k;
    k = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (oh[i]) k = ptr_t'(i);
    end
    return k;
  endfunction

  vec_t req, prio, prom, hi, lo, sel, ack, starved;
  vec_t rsp_q;
  ptr_t ptr_hi_q, ptr_lo_q, ptr_nxt;
  cls_e cls;
  logic grant;

  assign req  = bus.rd_req_i;
  assign prio = bus.rd_prio_i;

`ifdef WT_DCACHE_RD_ARB_AGING_EN
  logic [7:0] cnt_q [NumPorts];
  ptr_t       ptr_pro_q;

  always_comb begin
    starved = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      starved[k] = (cnt_q[k] == 8'(StarveLimit));
    end
  end

  // High-priority or idle ports keep a zero count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumPorts; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NumPorts; k++) begin
        if (!req[k] || prio[k] || ack[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] != 8'(StarveLimit)) begin
          cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_pro_q <= '0;
    end else if (grant && cls == CL_PRO) begin
      ptr_pro_q <= ptr_nxt;
    end
  end

  assign prom = req & starved;
`else
  assign starved = '0;
  assign prom    = '0;
`endif

  assign hi = req & prio & ~prom;
  assign lo = req & ~prio & ~prom;

  always_comb begin
    cls = CL_LO;
    sel = rr_pick(lo, ptr_lo_q);
    if (|hi) begin
      cls = CL_HI;
      sel = rr_pick(hi, ptr_hi_q);
    end
`ifdef WT_DCACHE_RD_ARB_AGING_EN
    if (|prom) begin
      cls = CL_PRO;
      sel = rr_pick(prom, ptr_pro_q);
    end
`endif
  end

  assign ack     = sel & {NumPorts{bus.mem_gnt_i}};
  assign grant   = |ack;
  assign ptr_nxt = ptr_t'((32'(enc(sel)) + 1) % NumPorts);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_hi_q <= '0;
      ptr_lo_q <= '0;
    end else if (grant) begin
      if (cls == CL_HI) ptr_hi_q <= ptr_nxt;
      if (cls == CL_LO) ptr_lo_q <= ptr_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= ack;
    end
  end

  // Idle cycles present port 0's fields to the arrays.
  always_comb begin
    bus.mem_tag_o      = bus.rd_tag_i[0];
    bus.mem_idx_o      = bus.rd_idx_i[0];
    bus.mem_off_o      = bus.rd_off_i[0];
    bus.mem_tag_only_o = bus.rd_tag_only_i[0];
    for (int unsigned k = 0; k < NumPorts; k++) begin
      if (sel[k]) begin
        bus.mem_tag_o      = bus.rd_tag_i[k];
        bus.mem_idx_o      = bus.rd_idx_i[k];
        bus.mem_off_o      = bus.rd_off_i[k];
        bus.mem_tag_only_o = bus.rd_tag_only_i[k];
      end
    end
  end

  assign bus.mem_req_o    = |req;
  assign bus.rd_ack_o     = ack;
  assign bus.rd_rsp_vld_o = rsp_q;
  assign bus.starved_o    = starved;

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Directed bench for wt_dcache_rd_arb; expectations follow
// WT_DCACHE_RD_ARB_AGING_EN when it is defined.
module tb_wt_dcache_rd_arb;
  localparam int unsigned N  = 3;
  localparam int unsigned TW = 8;
  localparam int unsigned IW = 6;
  localparam int unsigned OW = 4;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  wt_dcache_rd_arb_if #(
    .NumPorts(N), .TagWidth(TW),
    .IdxWidth(IW), .OffWidth(OW)
  ) bus ();

  wt_dcache_rd_arb #(
    .NumPorts(N), .TagWidth(TW),
    .IdxWidth(IW), .OffWidth(OW),
    .StarveLimit(SL)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.rd_req_i = '0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  logic [2:0] st_ack [6];
  logic [2:0] st_stv [6];

  initial begin
`ifdef WT_DCACHE_RD_ARB_AGING_EN
    st_ack = '{3'b001, 3'b010, 3'b001,
               3'b010, 3'b100, 3'b001};
    st_stv = '{3'b000, 3'b000, 3'b000,
               3'b000, 3'b100, 3'b000};
`else
    st_ack = '{3'b001, 3'b010, 3'b001,
               3'b010, 3'b001, 3'b010};
    st_stv = '{3'b000, 3'b000, 3'b000,
               3'b000, 3'b000, 3'b000};
`endif
    bus.rd_req_i      = '0;
    bus.rd_prio_i     = '0;
    bus.rd_tag_only_i = 3'b010;
    bus.rd_tag_i[0]   = 8'hA0;
    bus.rd_tag_i[1]   = 8'hA1;
    bus.rd_tag_i[2]   = 8'hA2;
    bus.rd_idx_i[0]   = 6'h10;
    bus.rd_idx_i[1]   = 6'h11;
    bus.rd_idx_i[2]   = 6'h12;
    bus.rd_off_i[0]   = 4'h1;
    bus.rd_off_i[1]   = 4'h2;
    bus.rd_off_i[2]   = 4'h3;
    bus.mem_gnt_i     = 1'b1;

    // reset state
    repeat (2) tick();
    chk("rst_rsp", 32'(bus.rd_rsp_vld_o), 0);
    chk("rst_stv", 32'(bus.starved_o), 0);
    chk("rst_ack", 32'(bus.rd_ack_o), 0);
    chk("rst_mreq", 32'(bus.mem_req_o), 0);
    chk("idle_tag", 32'(bus.mem_tag_o), 32'hA0);
    chk("idle_idx", 32'(bus.mem_idx_o), 32'h10);
    rst_n = 1'b1;
    tick();

    // single request, response one cycle later
    bus.rd_req_i = 3'b001;
    #1;
    chk("p0_ack", 32'(bus.rd_ack_o), 32'b001);
    chk("p0_mreq", 32'(bus.mem_req_o), 1);
    chk("p0_rsp0", 32'(bus.rd_rsp_vld_o), 0);
    tick();
    bus.rd_req_i = 3'b000;
    #1;
    chk("p0_rsp1", 32'(bus.rd_rsp_vld_o), 32'b001);
    chk("p0_noack", 32'(bus.rd_ack_o), 0);
    tick();
    chk("p0_rsp2", 32'(bus.rd_rsp_vld_o), 0);

    // field mux follows selected port
    bus.rd_req_i = 3'b010;
    #1;
    chk("mux_ack", 32'(bus.rd_ack_o), 32'b010);
    chk("mux_tag", 32'(bus.mem_tag_o), 32'hA1);
    chk("mux_idx", 32'(bus.mem_idx_o), 32'h11);
    chk("mux_off", 32'(bus.mem_off_o), 32'h2);
    chk("mux_to", 32'(bus.mem_tag_only_o), 1);

    // two high-priority ports alternate
    do_reset();
    bus.rd_prio_i = 3'b011;
    bus.rd_req_i  = 3'b011;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_hi", 32'(bus.rd_ack_o),
          (i % 2 == 0) ? 32'b001 : 32'b010);
      tick();
    end

    // low port 2 against two busy high ports
    do_reset();
    bus.rd_prio_i = 3'b011;
    bus.rd_req_i  = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stv_ack", 32'(bus.rd_ack_o), 32'(st_ack[i]));
      chk("stv_flag", 32'(bus.starved_o), 32'(st_stv[i]));
      tick();
    end

    // arrays busy: no acks, pointer holds
    do_reset();
    bus.rd_prio_i = 3'b111;
    bus.rd_req_i  = 3'b111;
    #1;
    chk("gnt_first", 32'(bus.rd_ack_o), 32'b001);
    tick();
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gnt0_ack", 32'(bus.rd_ack_o), 0);
      chk("gnt0_mreq", 32'(bus.mem_req_o), 1);
      tick();
      chk("gnt0_rsp", 32'(bus.rd_rsp_vld_o), 0);
    end
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("gnt1_ack", 32'(bus.rd_ack_o), 32'b010);
    tick();
    chk("gnt1_rsp", 32'(bus.rd_rsp_vld_o), 32'b010);

    // reset during a grant to port 1
    do_reset();
    bus.rd_prio_i = 3'b111;
    bus.rd_req_i  = 3'b010;
    #1;
    chk("mr_ack", 32'(bus.rd_ack_o), 32'b010);
    tick();
    chk("mr_ack2", 32'(bus.rd_ack_o), 32'b010);
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_clr", 32'(bus.rd_rsp_vld_o), 0);
    tick();
    chk("mr_rsp_rst", 32'(bus.rd_rsp_vld_o), 0);
    rst_n = 1'b1;
    bus.rd_req_i = 3'b111;
    #1;
    chk("mr_ptr0", 32'(bus.rd_ack_o), 32'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wt_dcache_rd_arb.md
# wt_dcache_rd_arb

Parametrised read-port arbiter for the write-through L1 data cache: merges NumPorts requesters (load unit, PTW, write buffer, and future ports) onto the single tag/data read port of the dcache memory arrays. Successor to the fixed three-port, hard-priority scheme. Adds per-class round-robin fairness, an aging mechanism that promotes starved low-priority ports, and a registered one-hot response strobe that marks the cycle the read data and hit vector are valid.

## Interface
- NumPorts, 3, number of requesting ports (≥2)
- TagWidth, DCACHE_TAG_WIDTH, tag bits per request
- IdxWidth, DCACHE_CL_IDX_WIDTH, cache-line index bits
- OffWidth, DCACHE_OFFSET_WIDTH, byte offset bits
- StarveLimit, 8, wait cycles before a low-priority port is promoted (1..255)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rd_req_i  in  NumPorts  per-port read request
- rd_prio_i  in  NumPorts  1 = high-priority class
- rd_tag_only_i  in  NumPorts  tag-only lookup
- rd_tag_i  in  NumPorts×TagWidth  request tag
- rd_idx_i  in  NumPorts×IdxWidth  request index
- rd_off_i  in  NumPorts×OffWidth  request offset
- rd_ack_o  out  NumPorts  one-hot grant, same cycle as request
- rd_rsp_vld_o  out  NumPorts  one-hot, one cycle after rd_ack_o
- mem_req_o  out  1  read issued to memory arrays
- mem_gnt_i  in  1  arrays accept a read this cycle (low during cache-line writes)
- mem_tag_o / mem_idx_o / mem_off_o / mem_tag_only_o  out  widths as above  muxed fields of selected port
- starved_o  out  NumPorts  port currently promoted

## Operation
- Selection order each cycle: promoted (starved) ports, then high-priority ports, then low-priority ports. Within each class, round-robin from that class's pointer, searching upward with wrap.
- Three pointers (promoted, high, low), each $clog2(NumPorts) bits. On an accepted grant to port k in class c, pointer c becomes (k+1) mod NumPorts. Other pointers hold.
- mem_req_o = |rd_req_i. Mem field outputs mux the selected port. When no port requests, the fields drive port 0's values.
- rd_ack_o[k] = sel[k] & mem_gnt_i. No ack while mem_gnt_i is low.
- Aging counter per port, 8 bits:
  - Increments when rd_req_i[k] & ~rd_prio_i[k] & ~rd_ack_o[k].
  - Saturates at StarveLimit.
  - Clears on ack or when the request drops.
  - starved_o[k] = (cnt[k] == StarveLimit).
- High-priority ports never age; their counters are held at 0.
- Requester rule: request and fields stay stable until ack. If a request is withdrawn, its counter clears and no protocol error is raised.
- rd_rsp_vld_o register ← rd_ack_o, every cycle.

## Timing
- Grant path is combinational: request → ack in 0 cycles. Response strobe arrives in exactly 1 cycle.
- Back-to-back grants to different or same ports are allowed every cycle.
- mem_gnt_i low: no acks, pointers hold, counters keep aging, rd_rsp_vld_o is 0 the next cycle.
- Reset values: pointers 0, counters 0, rd_rsp_vld_o 0, starved_o 0. Combinational outputs follow their inputs.
- Reset asserted mid-operation clears all state immediately. The response for a grant issued in the reset cycle is dropped.
- All ports requesting simultaneously: exactly one ack. With all ports in the same class, each is served within NumPorts grants.

## Configuration
- WT_DCACHE_RD_ARB_AGING_EN defined: aging counters and the promoted class exist as described.
- Not defined: counters and the promoted pointer are not instantiated, starved_o is tied to 0, and arbitration is round-robin within strict high-over-low priority.

## Test plan
- Reset, no requests: all outputs 0, mem_req_o=0. Assert rd_req_i=3'b001: ack=001 the same cycle, rsp_vld=001 one cycle later.
- rd_prio_i=3'b011, rd_req_i=3'b011 held, gnt=1: acks alternate 001, 010, 001, 010.
- NumPorts=3, StarveLimit=4, ports 0/1 high and continuously requesting, port 2 low and requesting: port 2 acked on the 5th cycle with starved_o[2]=1 in that cycle. The counter then clears.
- mem_gnt_i=0 for 3 cycles with rd_req_i=3'b111: no acks, rsp_vld=0; when gnt=1, ack goes to the port at the current pointer.
- rst_ni pulsed low while port 1 is acked: rd_rsp_vld_o=0 after reset, pointers return to 0.
- Macro undefined, same stimulus as the starvation case: port 2 is never acked and starved_o stays 000.
